// File: rtl/bp_pkg.sv
// Shared types for the branch-prediction update path: queue entry and the
// registered gshare update bundle.
package bp_pkg;

  localparam int GHR_BITS = 10;

  typedef struct packed {
    logic                valid;
    logic                resolved;
    logic                pred;
    logic                taken;
    logic [GHR_BITS-1:0] idx;
    logic [GHR_BITS-1:0] ghr;
  } bp_entry_t;

  typedef struct packed {
    logic                valid;
    logic                outcome;
    logic [GHR_BITS-1:0] idx;
    logic                mispredict;
    logic [GHR_BITS-1:0] ghr;
  } bp_update_t;

endpackage

// File: rtl/bp_update_queue.sv
// In-order queue of in-flight conditional-branch metadata; emits the gshare
// update bundle at retire and flushes everything younger on a mispredict.
module bp_update_queue #(
  parameter int GHR_BITS = bp_pkg::GHR_BITS,
  parameter int DEPTH    = 16,
  parameter int TAG_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [GHR_BITS-1:0] alloc_idx,
  input  logic [GHR_BITS-1:0] alloc_ghr,
  input  logic                alloc_pred,
  output logic [TAG_BITS-1:0] alloc_tag,
  input  logic                resolve_valid,
  input  logic [TAG_BITS-1:0] resolve_tag,
  input  logic                resolve_taken,
  input  logic                retire_valid,
  output logic                retire_ready,
  output logic                commit_valid,
  output logic                commit_outcome,
  output logic [GHR_BITS-1:0] commit_idx,
  output logic                mispredict,
  output logic [GHR_BITS-1:0] commit_ghr,
  output logic [TAG_BITS:0]   count,
  output logic [31:0]         perf_branches,
  output logic [31:0]         perf_mispredicts
);
  import bp_pkg::*;

  bp_entry_t           ent_q [DEPTH];
  bp_entry_t           ent_d [DEPTH];
  logic [TAG_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_BITS:0]   count_q, count_d;
  bp_update_t          upd_q, upd_d;
  logic [31:0]         perf_br_q, perf_mp_q;

  bp_entry_t head_e;
  logic      head_bypass, do_retire, do_alloc, outcome, mp;

  assign head_e      = ent_q[head_q];
  assign head_bypass = resolve_valid && (resolve_tag == head_q);
  assign alloc_ready = (count_q != (TAG_BITS+1)'(DEPTH));
  assign alloc_tag   = tail_q;
  // A mispredict on the update bus occupies the gshare write port this cycle.
  assign retire_ready = head_e.valid && (head_e.resolved || head_bypass) && !upd_q.mispredict;
  assign do_retire   = retire_valid && retire_ready;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign outcome     = head_e.resolved ? head_e.taken : resolve_taken;
  assign mp          = (outcome != head_e.pred);

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    upd_d  = upd_q;
    upd_d.valid      = 1'b0;
    upd_d.mispredict = 1'b0;

    if (resolve_valid && ent_q[resolve_tag].valid) begin
      ent_d[resolve_tag].resolved = 1'b1;
      ent_d[resolve_tag].taken    = resolve_taken;
    end

    if (do_retire) begin
      upd_d.valid      = 1'b1;
      upd_d.outcome    = outcome;
      upd_d.idx        = head_e.idx;
      upd_d.mispredict = mp;
      upd_d.ghr        = {head_e.ghr[GHR_BITS-2:0], outcome};
    end

    if (do_retire && mp) begin
      // Fetch is redirected, so any same-cycle alloc is dropped as well.
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid    = 1'b0;
        ent_d[i].resolved = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_retire) begin
        ent_d[head_q].valid    = 1'b0;
        ent_d[head_q].resolved = 1'b0;
        head_d = head_q + 1'b1;
      end
      if (do_alloc) begin
        ent_d[tail_q].valid    = 1'b1;
        ent_d[tail_q].resolved = 1'b0;
        ent_d[tail_q].pred     = alloc_pred;
        ent_d[tail_q].taken    = 1'b0;
        ent_d[tail_q].idx      = alloc_idx;
        ent_d[tail_q].ghr      = alloc_ghr;
        tail_d = tail_q + 1'b1;
      end
      case ({do_alloc, do_retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      upd_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      upd_q   <= upd_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_br_q <= '0;
    else if (do_retire && (perf_br_q != 32'hFFFF_FFFF)) perf_br_q <= perf_br_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_mp_q <= '0;
    else if (do_retire && mp && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_q <= perf_mp_q + 32'd1;
  end

  assign commit_valid     = upd_q.valid;
  assign commit_outcome   = upd_q.outcome;
  assign commit_idx       = upd_q.idx;
  assign mispredict       = upd_q.mispredict;
  assign commit_ghr       = upd_q.ghr;
  assign count            = count_q;
  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: fill/wrap, bypass retire, out-of-order
// resolve, mispredict flush and asynchronous reset.
module tb_bp_update_queue;
  localparam int GB = 10;
  localparam int TB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alloc_valid = 1'b0, alloc_pred = 1'b0;
  logic [GB-1:0] alloc_idx = '0, alloc_ghr = '0;
  logic          alloc_ready;
  logic [TB-1:0] alloc_tag;
  logic          resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic [TB-1:0] resolve_tag = '0;
  logic          retire_valid = 1'b0;
  logic          retire_ready;
  logic          commit_valid, commit_outcome, mispredict;
  logic [GB-1:0] commit_idx, commit_ghr;
  logic [TB:0]   count;
  logic [31:0]   perf_branches, perf_mispredicts;

  int checks = 0;
  int errors = 0;

  bp_update_queue dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .alloc_ghr(alloc_ghr), .alloc_pred(alloc_pred), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .commit_valid(commit_valid), .commit_outcome(commit_outcome), .commit_idx(commit_idx),
    .mispredict(mispredict), .commit_ghr(commit_ghr), .count(count),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; resolve_valid = 1'b0; retire_valid = 1'b0;
  endtask

  // Retiring while not ready is a protocol violation of the bench itself.
  always @(negedge clk) begin
    if (rst && retire_valid) begin
      checks++;
      assert (retire_ready === 1'b1) else begin
        errors++;
        $error("FAIL retire_protocol observed=%0b expected=1", retire_ready);
      end
    end
  end

  initial begin
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_retire_ready", retire_ready, 0);
    chk("rst_perf_br", perf_branches, 0);

    // Fill to full: tags 0..15
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1; alloc_pred = 1'b1;
      alloc_idx = GB'(32'h100 + i); alloc_ghr = GB'(i);
      #1;
      chk("fill_tag", alloc_tag, i);
      chk("fill_ready", alloc_ready, 1);
      step();
    end
    alloc_valid = 1'b0;
    chk("full_count", count, 16);
    chk("full_ready", alloc_ready, 0);
    alloc_valid = 1'b1;
    step();
    chk("full_17th_count", count, 16);
    chk("full_tail_wrap", alloc_tag, 0);

    // Full queue: alloc + bypass retire of head (pred 1, taken 1) same cycle
    resolve_valid = 1'b1; resolve_tag = 4'd0; resolve_taken = 1'b1;
    retire_valid = 1'b1;
    #1;
    chk("full_retire_ready", retire_ready, 1);
    step();
    idle();
    chk("full_ret_count", count, 15);
    chk("full_ret_cv", commit_valid, 1);
    chk("full_ret_idx", commit_idx, 32'h100);
    chk("full_ret_mp", mispredict, 0);
    chk("full_ret_out", commit_outcome, 1);
    chk("full_ret_ghr", commit_ghr, 32'h001);
    chk("full_ret_tail", alloc_tag, 0);
    chk("full_ret_perf", perf_branches, 1);

    // Asynchronous reset mid-operation, no clock edge
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_ready", alloc_ready, 1);
    chk("arst_cv", commit_valid, 0);
    chk("arst_perf_br", perf_branches, 0);
    chk("arst_perf_mp", perf_mispredicts, 0);
    step();
    rst = 1'b1;
    step();

    // Out-of-order resolve
    alloc_valid = 1'b1; alloc_pred = 1'b1; alloc_idx = 10'h010; alloc_ghr = 10'h020;
    step();
    alloc_idx = 10'h011; alloc_ghr = 10'h021;
    step();
    idle();
    #1;
    chk("ooo_not_ready", retire_ready, 0);
    resolve_valid = 1'b1; resolve_tag = 4'd1; resolve_taken = 1'b1;
    step();
    resolve_valid = 1'b0;
    #1;
    chk("ooo_young_only", retire_ready, 0);
    resolve_valid = 1'b1; resolve_tag = 4'd0; resolve_taken = 1'b1;
    step();
    resolve_valid = 1'b0;
    #1;
    chk("ooo_ready", retire_ready, 1);
    retire_valid = 1'b1;
    step();
    chk("ooo_cv0", commit_valid, 1);
    chk("ooo_idx0", commit_idx, 32'h010);
    chk("ooo_mp0", mispredict, 0);
    chk("ooo_ghr0", commit_ghr, 32'h041);
    step();
    retire_valid = 1'b0;
    chk("ooo_cv1", commit_valid, 1);
    chk("ooo_idx1", commit_idx, 32'h011);
    chk("ooo_ghr1", commit_ghr, 32'h043);
    step();
    chk("ooo_cv_off", commit_valid, 0);
    chk("ooo_idx_held", commit_idx, 32'h011);
    chk("ooo_count", count, 0);
    chk("ooo_perf", perf_branches, 2);

    // Mispredict flush with a same-cycle alloc
    alloc_valid = 1'b1; alloc_pred = 1'b1; alloc_idx = 10'h155; alloc_ghr = 10'h2AA;
    #1;
    chk("mp_tag", alloc_tag, 2);
    step();
    alloc_pred = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alloc_idx = GB'(32'h30 + i); alloc_ghr = GB'(32'h40 + i);
      step();
    end
    alloc_valid = 1'b0;
    chk("mp_fill_count", count, 4);
    resolve_valid = 1'b1; resolve_tag = 4'd2; resolve_taken = 1'b0;
    step();
    resolve_valid = 1'b0;
    alloc_valid = 1'b1; alloc_idx = 10'h3C3; alloc_ghr = 10'h111; alloc_pred = 1'b1;
    retire_valid = 1'b1;
    #1;
    chk("mp_ready", retire_ready, 1);
    step();
    idle();
    #1;
    chk("mp_pulse", mispredict, 1);
    chk("mp_cv", commit_valid, 1);
    chk("mp_out", commit_outcome, 0);
    chk("mp_idx", commit_idx, 32'h155);
    chk("mp_ghr", commit_ghr, 32'h154);
    chk("mp_count", count, 0);
    chk("mp_tail", alloc_tag, 0);
    chk("mp_block", retire_ready, 0);
    chk("mp_perf_mp", perf_mispredicts, 1);
    chk("mp_perf_br", perf_branches, 3);
    step();
    chk("mp_pulse_off", mispredict, 0);
    chk("mp_cv_off", commit_valid, 0);
    chk("mp_ghr_held", commit_ghr, 32'h154);

    // Same-cycle bypass, actual not-taken matches pred 0
    alloc_valid = 1'b1; alloc_pred = 1'b0; alloc_idx = 10'h00A; alloc_ghr = 10'h3FF;
    step();
    alloc_valid = 1'b0;
    resolve_valid = 1'b1; resolve_tag = 4'd0; resolve_taken = 1'b0;
    retire_valid = 1'b1;
    #1;
    chk("byp_ready", retire_ready, 1);
    step();
    idle();
    chk("byp_cv", commit_valid, 1);
    chk("byp_out", commit_outcome, 0);
    chk("byp_mp", mispredict, 0);
    chk("byp_idx", commit_idx, 32'h00A);
    chk("byp_ghr", commit_ghr, 32'h3FE);
    chk("byp_count", count, 0);

    // Second resolve overwrites the outcome; resolve to an empty slot ignored
    alloc_valid = 1'b1; alloc_pred = 1'b1; alloc_idx = 10'h002; alloc_ghr = 10'h001;
    #1;
    chk("ovr_tag", alloc_tag, 1);
    step();
    alloc_valid = 1'b0;
    resolve_valid = 1'b1; resolve_tag = 4'd5; resolve_taken = 1'b0;
    step();
    resolve_tag = 4'd1; resolve_taken = 1'b0;
    step();
    resolve_taken = 1'b1;
    step();
    resolve_valid = 1'b0;
    retire_valid = 1'b1;
    step();
    idle();
    chk("ovr_out", commit_outcome, 1);
    chk("ovr_mp", mispredict, 0);
    chk("ovr_ghr", commit_ghr, 32'h003);
    chk("ovr_count", count, 0);
    chk("ovr_perf_br", perf_branches, 5);
    chk("ovr_perf_mp", perf_mispredicts, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
